periph_wait_ctrl: RTL
=====================

// Module: periph_wait_ctrl
// PURPOSE
//  Parametrised stall/completion tracker for memory-mapped peripherals with a busy bit in a status register.
//  Sits beside the ex stage, with NUM_CH independent channels.
//  A store to a channel's window arms that channel and captures the destination GPR.
//  A later status load that shows busy==0 retires the channel: it pulses ready_o with the GPR address to ex.
//  Adds per-channel timeout, error reporting and re-arm handling.
// PARAMETERS
//  NUM_CH      4             number of tracked peripheral channels (1..8)
//  ADDR_W      32            memory address width
//  DATA_W      32            memory data width
//  REG_ADDR_W  5             GPR address width
//  BASE_ADDR   32'h7004_0000 channel 0 window base
//  CH_STRIDE   32'h100       window size; channel i base = BASE_ADDR + i*CH_STRIDE
//  STATUS_OFS  0             status register offset inside each window
//  BUSY_BIT    0             bit of status word: 1 = peripheral busy
//  TMO_W       16            timeout counter width
//  TMO_MAX     16'hFFFF      cycles in ARMED before timeout (>=1)
// PORTS
//  clk                 in   1           clock, rising edge
//  rst                 in   1           reset, asynchronous, active-low
//  start_i             in   1           ex enables tracking; held high while waiting
//  mem_req_i           in   1           memory access valid this cycle
//  mem_we_i            in   1           1 = store, 0 = load
//  mem_addr_i          in   ADDR_W      access address
//  mem_rdata_i         in   DATA_W      load data (valid with load req)
//  reg_waddr_i         in   REG_ADDR_W  destination GPR of current instruction
//  busy_o              out  1           stall request to ex
//  ready_o             out  1           1-cycle pulse: a channel completed
//  ready_reg_waddr_o   out  REG_ADDR_W  captured GPR of completed channel
//  ready_ch_o          out  3           index of completed channel
//  timeout_o           out  1           1-cycle pulse: a channel timed out
//  timeout_ch_o        out  3           index of timed-out channel
//  pending_o           out  NUM_CH      per-channel ARMED flags
// BEHAVIOUR
//  Reset (rst=0, async): all channels IDLE, counters 0. All outputs 0; captured GPR 0.
//  Hit: mem_req_i & mem_addr_i in [base_i, base_i+CH_STRIDE). Status hit additionally requires addr == base_i+STATUS_OFS.
//  Channel FSM per channel, IDLE -> ARMED -> IDLE:
//   IDLE->ARMED: start_i & hit & mem_we_i. Capture reg_waddr_i, counter<=0.
//   ARMED, store hit again: stay ARMED; recapture reg_waddr_i; counter<=0.
//   ARMED, status load with mem_rdata_i[BUSY_BIT]==0: ->IDLE. Next edge: ready_o=1, ready_ch_o=i, ready_reg_waddr_o=captured.
//   ARMED, status load with busy bit 1: no change, counter keeps running.
//   ARMED, counter==TMO_MAX: ->IDLE. Next edge: timeout_o=1, timeout_ch_o=i, no ready.
//   Counter increments by 1 per cycle in ARMED. It saturates only via the timeout exit and never wraps.
//  Completion and timeout on the same channel in the same cycle: completion wins, no timeout.
//  Completion on ch a and timeout on ch b in the same cycle: both pulses fire on the same edge.
//  Multiple simultaneous timeouts: lowest index reported; others time out on following cycles.
//   Their counters hold at TMO_MAX until reported.
//  start_i low: all ARMED channels abort to IDLE next edge. No ready and no timeout are generated.
//  Accesses outside all windows and cycles with mem_req_i=0 have no effect.
//  ready_o, timeout_o: registered, high exactly 1 cycle. Their data outputs hold the last value when the pulse is low.
//  busy_o: combinational = start_i & |pending_o & ~(completion this cycle).
//  Latency: status load at cycle N -> ready_o at N+1, busy_o low at N.
//  Reset asserted mid-operation: immediate abort, no pulse on release.
// STRUCTURE
//  Shared defines: state encoding (CH_IDLE/CH_ARMED), RegAddrBus, MemAddrBus, MemBus.
//  Sub-module periph_wait_chan: one channel FSM, counter, capture and hit decode. Instantiate with generate over NUM_CH.
//  Top level: priority encoders for the ready/timeout pulses and the output registers.
// TESTING
//  1. Store 0x7004_0000 (rd=5), 3 status loads with busy=1, then busy=0 -> ready_o 1 cycle, waddr=5, ch=0.
//  2. Store ch2 (0x7004_0200, rd=9), no status load for TMO_MAX=8 -> timeout_o pulse, ch=2, pending_o[2]=0, no ready.
//  3. ch0 armed rd=3, re-store rd=7 -> completion returns waddr=7; counter restarted at re-store.
//  4. ch1 and ch3 armed, start_i dropped 1 cycle -> pending_o=0, busy_o=0, no pulses.
//  5. Status busy=0 read on same cycle counter hits TMO_MAX -> ready_o only.
//  6. Async rst low mid-ARMED, not on a clock edge -> outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/periph_wait_ctrl_pkg.sv
// rtl/periph_wait_ctrl_pkg.sv - shared types for the peripheral wait/completion tracker
package periph_wait_ctrl_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_e;

    typedef logic [GPR_ADDR_W-1:0] RegAddrBus;
    typedef logic [MEM_ADDR_W-1:0] MemAddrBus;
    typedef logic [MEM_DATA_W-1:0] MemBus;

endpackage

// File: rtl/periph_wait_chan.sv
// rtl/periph_wait_chan.sv - one tracked channel: window decode, arm/retire FSM, timeout counter
module periph_wait_chan
    import periph_wait_ctrl_pkg::*;
#(
    parameter int                  ADDR_W     = 32,
    parameter int                  DATA_W     = 32,
    parameter int                  REG_ADDR_W = 5,
    parameter int                  TMO_W      = 16,
    parameter int                  BUSY_BIT   = 0,
    parameter logic [ADDR_W-1:0]   CH_BASE    = 32'h7004_0000,
    parameter logic [ADDR_W-1:0]   CH_STRIDE  = 32'h100,
    parameter logic [ADDR_W-1:0]   STATUS_OFS = '0,
    parameter logic [TMO_W-1:0]    TMO_MAX    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  tmo_grant_i,
    output logic                  pending_o,
    output logic                  done_o,
    output logic                  tmo_req_o,
    output logic [REG_ADDR_W-1:0] waddr_o
);

    ch_state_e             state_q, state_d;
    logic [TMO_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0]     ofs;
    logic                  in_win, store_hit, stat_load, armed;
    logic                  unused_rdata;

    assign ofs          = mem_addr_i - CH_BASE;
    assign in_win       = mem_req_i && (mem_addr_i >= CH_BASE) && (ofs < CH_STRIDE);
    assign store_hit    = in_win && mem_we_i;
    assign stat_load    = in_win && !mem_we_i && (ofs == STATUS_OFS);
    assign armed        = (state_q == CH_ARMED);
    assign unused_rdata = ^mem_rdata_i;

    // Completion outranks a timeout that matures in the same cycle; a re-store outranks both.
    assign done_o    = armed && start_i && !store_hit && stat_load && !mem_rdata_i[BUSY_BIT];
    assign tmo_req_o = armed && start_i && !store_hit && !done_o && (cnt_q == TMO_MAX);
    assign pending_o = armed;
    assign waddr_o   = waddr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        case (state_q)
            CH_IDLE: begin
                if (start_i && store_hit) begin
                    state_d = CH_ARMED;
                    waddr_d = reg_waddr_i;
                    cnt_d   = '0;
                end
            end
            CH_ARMED: begin
                if (!start_i) begin
                    state_d = CH_IDLE;
                end else if (store_hit) begin
                    waddr_d = reg_waddr_i;
                    cnt_d   = '0;
                end else if (done_o) begin
                    state_d = CH_IDLE;
                end else if (tmo_req_o) begin
                    // Counter holds at TMO_MAX until the top reports this channel.
                    if (tmo_grant_i) state_d = CH_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: rtl/periph_wait_ctrl.sv
// rtl/periph_wait_ctrl.sv - multi-channel peripheral stall/completion tracker beside ex
module periph_wait_ctrl
    import periph_wait_ctrl_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                REG_ADDR_W = 5,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h7004_0000,
    parameter logic [ADDR_W-1:0] CH_STRIDE  = 32'h100,
    parameter logic [ADDR_W-1:0] STATUS_OFS = '0,
    parameter int                BUSY_BIT   = 0,
    parameter int                TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TMO_MAX    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [REG_ADDR_W-1:0] ready_reg_waddr_o,
    output logic [2:0]            ready_ch_o,
    output logic                  timeout_o,
    output logic [2:0]            timeout_ch_o,
    output logic [NUM_CH-1:0]     pending_o
);

    logic [NUM_CH-1:0]     done, tmo_req, tmo_grant;
    logic [REG_ADDR_W-1:0] ch_waddr [NUM_CH];
    logic [2:0]            done_idx, tmo_idx;
    logic [REG_ADDR_W-1:0] done_waddr;

    logic                  ready_q, ready_d, timeout_q, timeout_d;
    logic [2:0]            ready_ch_q, ready_ch_d, timeout_ch_q, timeout_ch_d;
    logic [REG_ADDR_W-1:0] ready_waddr_q, ready_waddr_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        periph_wait_chan #(
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .TMO_W      (TMO_W),
            .BUSY_BIT   (BUSY_BIT),
            .CH_BASE    (BASE_ADDR + ADDR_W'(i) * CH_STRIDE),
            .CH_STRIDE  (CH_STRIDE),
            .STATUS_OFS (STATUS_OFS),
            .TMO_MAX    (TMO_MAX)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .start_i     (start_i),
            .mem_req_i   (mem_req_i),
            .mem_we_i    (mem_we_i),
            .mem_addr_i  (mem_addr_i),
            .mem_rdata_i (mem_rdata_i),
            .reg_waddr_i (reg_waddr_i),
            .tmo_grant_i (tmo_grant[i]),
            .pending_o   (pending_o[i]),
            .done_o      (done[i]),
            .tmo_req_o   (tmo_req[i]),
            .waddr_o     (ch_waddr[i])
        );
    end

    // Isolate the lowest pending timeout; the others wait at TMO_MAX for later cycles.
    assign tmo_grant = tmo_req & (~tmo_req + NUM_CH'(1));

    always_comb begin
        done_idx   = '0;
        done_waddr = '0;
        tmo_idx    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (done[i]) begin
                done_idx   = 3'(i);
                done_waddr = ch_waddr[i];
            end
            if (tmo_req[i]) tmo_idx = 3'(i);
        end
    end

    always_comb begin
        ready_d       = |done;
        ready_ch_d    = ready_ch_q;
        ready_waddr_d = ready_waddr_q;
        timeout_d     = |tmo_req;
        timeout_ch_d  = timeout_ch_q;
        if (|done) begin
            ready_ch_d    = done_idx;
            ready_waddr_d = done_waddr;
        end
        if (|tmo_req) timeout_ch_d = tmo_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q       <= 1'b0;
            ready_ch_q    <= '0;
            ready_waddr_q <= '0;
            timeout_q     <= 1'b0;
            timeout_ch_q  <= '0;
        end else begin
            ready_q       <= ready_d;
            ready_ch_q    <= ready_ch_d;
            ready_waddr_q <= ready_waddr_d;
            timeout_q     <= timeout_d;
            timeout_ch_q  <= timeout_ch_d;
        end
    end

    assign busy_o            = start_i && (|pending_o) && !(|done);
    assign ready_o           = ready_q;
    assign ready_ch_o        = ready_ch_q;
    assign ready_reg_waddr_o = ready_waddr_q;
    assign timeout_o         = timeout_q;
    assign timeout_ch_o      = timeout_ch_q;

endmodule
